// File: rtl/sha1_pkg.sv
// sha1_pkg: shared definitions for the multi-round SHA-1 compression core.
//   - SHA1_NUM_ROUNDS, the initial hash value H0_0..H0_4 and the round constants
//   - ctrl_state_e: control FSM states (IDLE / ROUNDS / DONE)
//   - sha1_f / sha1_k: round function and constant selected by the 20-round group
//   - rotl1 / rotl5 / rotl30: fixed rotate-left helpers
package sha1_pkg;

    localparam int SHA1_NUM_ROUNDS = 80;

    localparam logic [31:0] H0_0 = 32'h6745_2301;
    localparam logic [31:0] H0_1 = 32'hefcd_ab89;
    localparam logic [31:0] H0_2 = 32'h98ba_dcfe;
    localparam logic [31:0] H0_3 = 32'h1032_5476;
    localparam logic [31:0] H0_4 = 32'hc3d2_e1f0;

    localparam logic [31:0] K_0 = 32'h5a82_7999;
    localparam logic [31:0] K_1 = 32'h6ed9_eba1;
    localparam logic [31:0] K_2 = 32'h8f1b_bcdc;
    localparam logic [31:0] K_3 = 32'hca62_c1d6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUNDS = 2'd1,
        DONE   = 2'd2
    } ctrl_state_e;

    function automatic logic [31:0] rotl1(input logic [31:0] x);
        return {x[30:0], x[31]};
    endfunction

    function automatic logic [31:0] rotl5(input logic [31:0] x);
        return {x[26:0], x[31:27]};
    endfunction

    function automatic logic [31:0] rotl30(input logic [31:0] x);
        return {x[1:0], x[31:2]};
    endfunction

    // t_group is the round index divided by 20 (0..3).
    function automatic logic [31:0] sha1_f(input logic [1:0]  t_group,
                                           input logic [31:0] b,
                                           input logic [31:0] c,
                                           input logic [31:0] d);
        logic [31:0] f;
        case (t_group)
            2'd0:    f = (b & c) | (~b & d);
            2'd1:    f = b ^ c ^ d;
            2'd2:    f = (b & c) | (b & d) | (c & d);
            2'd3:    f = b ^ c ^ d;
            default: f = b ^ c ^ d;
        endcase
        return f;
    endfunction

    function automatic logic [31:0] sha1_k(input logic [1:0] t_group);
        logic [31:0] k;
        case (t_group)
            2'd0:    k = K_0;
            2'd1:    k = K_1;
            2'd2:    k = K_2;
            2'd3:    k = K_3;
            default: k = K_3;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/sha1_w_mem_mr.sv
// sha1_w_mem_mr: 16-word sliding message-schedule window producing R words per cycle.
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : capture the 512-bit block (word 0 from bits [511:480])
//   advance      : slide the window forward by ROUNDS_PER_CYCLE words
//   block        : message block
//   w            : w[i] = W[t+i] for the current round t, i = 0..R-1
module sha1_w_mem_mr
    import sha1_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               load,
    input  logic                               advance,
    input  logic [511:0]                       block,
    output logic [ROUNDS_PER_CYCLE-1:0][31:0]  w
);

    localparam int R   = ROUNDS_PER_CYCLE;
    localparam int EXT = 16 + R;

    // window_r[0] always holds W[t]; window_r[15] holds W[t+15].
    logic [15:0][31:0]    window_r;
    logic [EXT-1:0][31:0] ext_s;

    // Extends the window by R freshly scheduled words. Each new word may depend on
    // one produced earlier in the same cycle (W[t+19] uses W[t+16] when R=4).
    function automatic logic [EXT-1:0][31:0] w_extend(input logic [15:0][31:0] win);
        logic [EXT-1:0][31:0] ext;
        ext       = '0;
        ext[15:0] = win;
        for (int j = 0; j < R; j++) begin
            ext[16+j] = rotl1(ext[13+j] ^ ext[8+j] ^ ext[2+j] ^ ext[j]);
        end
        return ext;
    endfunction

    // Window extension for the current round group.
    always_comb begin
        ext_s = w_extend(window_r);
    end

    assign w = ext_s[R-1:0];

    // Window register: load a new block or slide forward by R words.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            window_r <= {16{32'h0000_0000}};
        end else if (load) begin
            for (int i = 0; i < 16; i++) begin
                window_r[i] <= block[511 - 32*i -: 32];
            end
        end else if (advance) begin
            window_r <= ext_s[EXT-1:R];
        end else begin
            window_r <= window_r;
        end
    end

endmodule

// File: rtl/sha1_core_mr.sv
// sha1_core_mr: SHA-1 compression core, ROUNDS_PER_CYCLE (1, 2 or 4) rounds per clock.
//   clk, reset_n : clock, asynchronous active-low reset
//   init         : load the standard IV into H and compress block
//   next         : compress block continuing from the current H
//   iv_load, iv  : load H from iv ({H0..H4}) without compressing
//   abort        : cancel the block in progress (only acted on during ROUNDS)
//   block        : 512-bit pre-padded block, sampled on the start edge only
//   ready        : core idle, commands accepted
//   digest       : {H0..H4}
//   digest_valid : digest is the result of a completed block
module sha1_core_mr
    import sha1_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         init,
    input  logic         next,
    input  logic         iv_load,
    input  logic [159:0] iv,
    input  logic         abort,
    input  logic [511:0] block,
    output logic         ready,
    output logic [159:0] digest,
    output logic         digest_valid
);

    localparam int R = ROUNDS_PER_CYCLE;
    localparam logic [6:0] R_STEP   = 7'(R);
    localparam logic [6:0] LAST_CTR = 7'(SHA1_NUM_ROUNDS - R);

    // R must divide 20 so that every cycle stays inside one f/k group.
    if ((R != 1) && (R != 2) && (R != 4)) begin : g_bad_rounds
        $error("sha1_core_mr: ROUNDS_PER_CYCLE must be 1, 2 or 4");
    end

    ctrl_state_e state_r, state_next_s;

    logic [6:0]  round_ctr_r;
    logic [31:0] a_r, b_r, c_r, d_r, e_r;
    logic [31:0] h0_r, h1_r, h2_r, h3_r, h4_r;
    logic        digest_valid_r;
    logic        ready_r;

    logic start_init_s, start_next_s, load_iv_s, round_step_s, finish_s;
    logic [1:0]  grp_s;
    logic [31:0] k_s;
    logic [31:0] a_next_s, b_next_s, c_next_s, d_next_s, e_next_s;
    logic [R-1:0][31:0] w_s;

    sha1_w_mem_mr #(
        .ROUNDS_PER_CYCLE (R)
    ) u_w_mem (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (start_init_s | start_next_s),
        .advance (round_step_s),
        .block   (block),
        .w       (w_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (init || next) begin
                    state_next_s = ROUNDS;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ROUNDS: begin
                if (abort) begin
                    state_next_s = IDLE;
                end else if (round_ctr_r == LAST_CTR) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = ROUNDS;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // FSM output decode: one-cycle datapath strobes, command priority init > next > iv_load.
    always_comb begin
        start_init_s = 1'b0;
        start_next_s = 1'b0;
        load_iv_s    = 1'b0;
        round_step_s = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (init) begin
                    start_init_s = 1'b1;
                end else if (next) begin
                    start_next_s = 1'b1;
                end else if (iv_load) begin
                    load_iv_s = 1'b1;
                end else begin
                    load_iv_s = 1'b0;
                end
            end
            ROUNDS: begin
                if (abort) begin
                    round_step_s = 1'b0;
                end else begin
                    round_step_s = 1'b1;
                end
            end
            DONE:    finish_s = 1'b1;
            default: finish_s = 1'b0;
        endcase
    end

    // Round group of the current cycle (all R rounds share it).
    always_comb begin
        if (round_ctr_r < 7'd20) begin
            grp_s = 2'd0;
        end else if (round_ctr_r < 7'd40) begin
            grp_s = 2'd1;
        end else if (round_ctr_r < 7'd60) begin
            grp_s = 2'd2;
        end else begin
            grp_s = 2'd3;
        end
    end

    assign k_s = sha1_k(grp_s);

    // R chained combinational rounds; stage i computes round t+i.
    for (genvar i = 0; i < R; i++) begin : g_round
        logic [31:0] a_in_s, b_in_s, c_in_s, d_in_s, e_in_s;
        logic [31:0] a_out_s, b_out_s, c_out_s, d_out_s, e_out_s;
        if (i == 0) begin : g_head
            assign a_in_s = a_r;
            assign b_in_s = b_r;
            assign c_in_s = c_r;
            assign d_in_s = d_r;
            assign e_in_s = e_r;
        end else begin : g_link
            assign a_in_s = g_round[i-1].a_out_s;
            assign b_in_s = g_round[i-1].b_out_s;
            assign c_in_s = g_round[i-1].c_out_s;
            assign d_in_s = g_round[i-1].d_out_s;
            assign e_in_s = g_round[i-1].e_out_s;
        end
        assign a_out_s = rotl5(a_in_s) + sha1_f(grp_s, b_in_s, c_in_s, d_in_s)
                       + e_in_s + k_s + w_s[i];
        assign b_out_s = a_in_s;
        assign c_out_s = rotl30(b_in_s);
        assign d_out_s = c_in_s;
        assign e_out_s = d_in_s;
    end

    assign a_next_s = g_round[R-1].a_out_s;
    assign b_next_s = g_round[R-1].b_out_s;
    assign c_next_s = g_round[R-1].c_out_s;
    assign d_next_s = g_round[R-1].d_out_s;
    assign e_next_s = g_round[R-1].e_out_s;

    // Round counter; cleared on start, abort and after the final step so it never passes 80-R.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            round_ctr_r <= 7'd0;
        end else if (start_init_s || start_next_s) begin
            round_ctr_r <= 7'd0;
        end else if (round_step_s) begin
            if (round_ctr_r == LAST_CTR) begin
                round_ctr_r <= 7'd0;
            end else begin
                round_ctr_r <= round_ctr_r + R_STEP;
            end
        end else if (state_r == ROUNDS) begin
            round_ctr_r <= 7'd0;
        end else begin
            round_ctr_r <= round_ctr_r;
        end
    end

    // Working variables a..e.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_r <= 32'h0000_0000;
            b_r <= 32'h0000_0000;
            c_r <= 32'h0000_0000;
            d_r <= 32'h0000_0000;
            e_r <= 32'h0000_0000;
        end else if (start_init_s) begin
            a_r <= H0_0;
            b_r <= H0_1;
            c_r <= H0_2;
            d_r <= H0_3;
            e_r <= H0_4;
        end else if (start_next_s) begin
            a_r <= h0_r;
            b_r <= h1_r;
            c_r <= h2_r;
            d_r <= h3_r;
            e_r <= h4_r;
        end else if (round_step_s) begin
            a_r <= a_next_s;
            b_r <= b_next_s;
            c_r <= c_next_s;
            d_r <= d_next_s;
            e_r <= e_next_s;
        end else begin
            a_r <= a_r;
            b_r <= b_r;
            c_r <= c_r;
            d_r <= d_r;
            e_r <= e_r;
        end
    end

    // Chaining value H. An init rewrites H at the start edge, so an aborted init leaves the IV.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h0_r <= 32'h0000_0000;
            h1_r <= 32'h0000_0000;
            h2_r <= 32'h0000_0000;
            h3_r <= 32'h0000_0000;
            h4_r <= 32'h0000_0000;
        end else if (start_init_s) begin
            h0_r <= H0_0;
            h1_r <= H0_1;
            h2_r <= H0_2;
            h3_r <= H0_3;
            h4_r <= H0_4;
        end else if (load_iv_s) begin
            h0_r <= iv[159:128];
            h1_r <= iv[127:96];
            h2_r <= iv[95:64];
            h3_r <= iv[63:32];
            h4_r <= iv[31:0];
        end else if (finish_s) begin
            h0_r <= h0_r + a_r;
            h1_r <= h1_r + b_r;
            h2_r <= h2_r + c_r;
            h3_r <= h3_r + d_r;
            h4_r <= h4_r + e_r;
        end else begin
            h0_r <= h0_r;
            h1_r <= h1_r;
            h2_r <= h2_r;
            h3_r <= h3_r;
            h4_r <= h4_r;
        end
    end

    // digest_valid: cleared by any accepted command, set when DONE folds a..e into H.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digest_valid_r <= 1'b0;
        end else if (start_init_s || start_next_s || load_iv_s) begin
            digest_valid_r <= 1'b0;
        end else if (finish_s) begin
            digest_valid_r <= 1'b1;
        end else begin
            digest_valid_r <= digest_valid_r;
        end
    end

    // ready is registered from the next state so it is high exactly while the FSM is in IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_r <= 1'b1;
        end else begin
            ready_r <= (state_next_s == IDLE);
        end
    end

    assign ready        = ready_r;
    assign digest       = {h0_r, h1_r, h2_r, h3_r, h4_r};
    assign digest_valid = digest_valid_r;

endmodule

// File: tb/tb_sha1_core_mr.sv
// tb_sha1_core_mr: scoreboard bench for sha1_core_mr, one instance each for R = 1, 2, 4.
module tb_sha1_core_mr;

    localparam logic [159:0] IV_STD    = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
    localparam logic [159:0] DIG_ABC   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
    localparam logic [159:0] DIG_EMPTY = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
    localparam logic [159:0] DIG_TWO   = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         init_v    [3];
    logic         next_v    [3];
    logic         iv_load_v [3];
    logic         abort_v   [3];
    logic [159:0] iv_v      [3];
    logic [511:0] block_v   [3];
    logic         ready_v   [3];
    logic [159:0] digest_v  [3];
    logic         dv_v      [3];

    int tests_run    = 0;
    int tests_failed = 0;

    logic [159:0] exp_q [$];
    logic [511:0] blk_abc, blk_empty, blk_two1, blk_two2;
    logic [159:0] inter_dig;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sha1_core_mr #(
            .ROUNDS_PER_CYCLE (1 << g)
        ) u_dut (
            .clk          (clk),
            .reset_n      (reset_n),
            .init         (init_v[g]),
            .next         (next_v[g]),
            .iv_load      (iv_load_v[g]),
            .iv           (iv_v[g]),
            .abort        (abort_v[g]),
            .block        (block_v[g]),
            .ready        (ready_v[g]),
            .digest       (digest_v[g]),
            .digest_valid (dv_v[g])
        );
    end

    // Reference compression: full 80-word schedule, one round per loop iteration.
    function automatic logic [159:0] sha1_model(input logic [159:0] hin, input logic [511:0] blk);
        logic [31:0] w [0:79];
        logic [31:0] a, b, c, d, e, f, k, x, tmp;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 80; t++) begin
            x    = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
            w[t] = {x[30:0], x[31]};
        end
        a = hin[159:128]; b = hin[127:96]; c = hin[95:64]; d = hin[63:32]; e = hin[31:0];
        for (int t = 0; t < 80; t++) begin
            if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
            else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ed9eba1; end
            else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
            else             begin f = b ^ c ^ d;                   k = 32'hca62c1d6; end
            tmp = {a[26:0], a[31:27]} + f + e + k + w[t];
            e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
        end
        return {hin[159:128] + a, hin[127:96] + b, hin[95:64] + c, hin[63:32] + d, hin[31:0] + e};
    endfunction

    // Drives one command for a single edge, then scrambles block/iv.
    task automatic issue(input int idx, input logic c_init, input logic c_next, input logic c_iv,
                         input logic [159:0] ivv, input logic [511:0] blk);
        init_v[idx]    = c_init;
        next_v[idx]    = c_next;
        iv_load_v[idx] = c_iv;
        iv_v[idx]      = ivv;
        block_v[idx]   = blk;
        @(posedge clk); #1;
        init_v[idx]    = 1'b0;
        next_v[idx]    = 1'b0;
        iv_load_v[idx] = 1'b0;
        block_v[idx]   = {16{$urandom()}};
        iv_v[idx]      = {5{$urandom()}};
    endtask

    task automatic start_block(input int idx, input logic c_init, input logic c_next, input logic c_iv,
                               input logic [159:0] ivv, input logic [511:0] blk, input logic [159:0] exp);
        exp_q.push_back(exp);
        issue(idx, c_init, c_next, c_iv, ivv, blk);
    endtask

    // Waits for digest_valid; edges counted from the start edge (cnt0 edges already elapsed).
    task automatic collect(input int idx, input string name, input int cnt0, input int exp_lat);
        int cnt = cnt0;
        bit got = 1'b0;
        bit early_ready = 1'b0;
        logic [159:0] exp;
        while (!got && cnt < 400) begin
            @(posedge clk); #1;
            cnt++;
            if (dv_v[idx]) got = 1'b1;
            else if (ready_v[idx]) early_ready = 1'b1;
            else early_ready = early_ready;
        end
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL %s timeout: digest_valid not seen within %0d edges (want %0d)", name, cnt, exp_lat);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL %s: digest_valid with empty scoreboard", name);
        end else begin
            exp = exp_q.pop_front();
            if (digest_v[idx] !== exp) begin
                tests_failed++;
                $display("FAIL %s digest: got %h want %h", name, digest_v[idx], exp);
            end
            tests_run++;
            if (cnt !== exp_lat) begin
                tests_failed++;
                $display("FAIL %s latency: got %0d want %0d", name, cnt, exp_lat);
            end
            tests_run++;
            if (ready_v[idx] !== 1'b1 || early_ready) begin
                tests_failed++;
                $display("FAIL %s ready: got %b (early %b) want 1 (early 0)", name, ready_v[idx], early_ready);
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (ready_v[i] !== 1'b1 || digest_v[i] !== 160'h0 || dv_v[i] !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset[%0d]: got ready=%b digest=%h valid=%b want 1/0/0",
                         i, ready_v[i], digest_v[i], dv_v[i]);
            end
        end
    endtask

    task automatic test_abc();
        start_block(0, 1'b1, 1'b0, 1'b0, 160'h0, blk_abc, DIG_ABC);
        collect(0, "abc_r1", 1, 82);
    endtask

    task automatic test_empty_all_r();
        for (int i = 0; i < 3; i++) begin
            start_block(i, 1'b1, 1'b0, 1'b0, 160'h0, blk_empty, DIG_EMPTY);
            collect(i, $sformatf("empty_r%0d", 1 << i), 1, 80 / (1 << i) + 2);
        end
        start_block(2, 1'b1, 1'b0, 1'b0, 160'h0, blk_abc, DIG_ABC);
        collect(2, "abc_r4", 1, 22);
        start_block(1, 1'b1, 1'b0, 1'b0, 160'h0, blk_two1, sha1_model(IV_STD, blk_two1));
        collect(1, "two1_r2", 1, 42);
        start_block(1, 1'b0, 1'b1, 1'b0, 160'h0, blk_two2, DIG_TWO);
        collect(1, "two2_r2", 1, 42);
    endtask

    task automatic test_back_to_back();
        start_block(0, 1'b1, 1'b0, 1'b0, 160'h0, blk_two1, inter_dig);
        collect(0, "two1_r1", 1, 82);
        start_block(0, 1'b0, 1'b1, 1'b0, 160'h0, blk_two2, DIG_TWO);
        collect(0, "two2_r1", 1, 82);
    endtask

    task automatic test_resume();
        issue(0, 1'b0, 1'b0, 1'b1, inter_dig, {16{32'hdeadbeef}});
        tests_run++;
        if (digest_v[0] !== inter_dig || dv_v[0] !== 1'b0 || ready_v[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL iv_load: got digest=%h valid=%b ready=%b want %h/0/1",
                     digest_v[0], dv_v[0], ready_v[0], inter_dig);
        end
        start_block(0, 1'b0, 1'b1, 1'b0, 160'h0, blk_two2, DIG_TWO);
        collect(0, "resume", 1, 82);
    endtask

    task automatic test_abort();
        issue(0, 1'b0, 1'b1, 1'b0, 160'h0, blk_two1);
        repeat (9) begin @(posedge clk); #1; end
        tests_run++;
        if (ready_v[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_pre ready: got %b want 0", ready_v[0]);
        end
        abort_v[0] = 1'b1;
        @(posedge clk); #1;
        abort_v[0] = 1'b0;
        tests_run++;
        if (ready_v[0] !== 1'b1 || dv_v[0] !== 1'b0 || digest_v[0] !== DIG_TWO) begin
            tests_failed++;
            $display("FAIL abort_next: got ready=%b valid=%b digest=%h want 1/0/%h",
                     ready_v[0], dv_v[0], digest_v[0], DIG_TWO);
        end
        start_block(0, 1'b1, 1'b0, 1'b0, 160'h0, blk_abc, DIG_ABC);
        collect(0, "abc_after_abort", 1, 82);
        issue(0, 1'b1, 1'b0, 1'b0, 160'h0, blk_empty);
        repeat (4) begin @(posedge clk); #1; end
        abort_v[0] = 1'b1;
        @(posedge clk); #1;
        abort_v[0] = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        tests_run++;
        if (ready_v[0] !== 1'b1 || dv_v[0] !== 1'b0 || digest_v[0] !== IV_STD) begin
            tests_failed++;
            $display("FAIL abort_init: got ready=%b valid=%b digest=%h want 1/0/%h",
                     ready_v[0], dv_v[0], digest_v[0], IV_STD);
        end
    endtask

    task automatic test_cmd_handling();
        start_block(0, 1'b1, 1'b1, 1'b1, {5{32'h1234_5678}}, blk_abc, DIG_ABC);
        collect(0, "priority", 1, 82);
        start_block(0, 1'b0, 1'b1, 1'b0, 160'h0, blk_empty, sha1_model(DIG_ABC, blk_empty));
        repeat (5) begin @(posedge clk); #1; end
        init_v[0] = 1'b1; next_v[0] = 1'b1; iv_load_v[0] = 1'b1;
        iv_v[0] = {5{32'h0bad_f00d}}; block_v[0] = blk_abc;
        @(posedge clk); #1;
        init_v[0] = 1'b0; next_v[0] = 1'b0; iv_load_v[0] = 1'b0;
        collect(0, "ignored_cmds", 7, 82);
    endtask

    task automatic test_reset_mid();
        issue(0, 1'b1, 1'b0, 1'b0, 160'h0, blk_abc);
        repeat (20) begin @(posedge clk); #1; end
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (digest_v[0] !== 160'h0 || dv_v[0] !== 1'b0 || ready_v[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid: got digest=%h valid=%b ready=%b want 0/0/1",
                     digest_v[0], dv_v[0], ready_v[0]);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        tests_run++;
        if (dv_v[0] !== 1'b0 || ready_v[0] !== 1'b1 || digest_v[0] !== 160'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_idle: got valid=%b ready=%b digest=%h want 0/1/0",
                     dv_v[0], ready_v[0], digest_v[0]);
        end
        start_block(0, 1'b1, 1'b0, 1'b0, 160'h0, blk_empty, DIG_EMPTY);
        collect(0, "after_reset", 1, 82);
    endtask

    initial begin
        blk_abc   = '0; blk_abc[511:480] = 32'h61626380; blk_abc[31:0] = 32'h00000018;
        blk_empty = '0; blk_empty[511:480] = 32'h80000000;
        blk_two1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                     32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                     32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        blk_two2  = '0; blk_two2[31:0] = 32'h000001c0;
        inter_dig = sha1_model(IV_STD, blk_two1);
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            init_v[i] = 1'b0; next_v[i] = 1'b0; iv_load_v[i] = 1'b0; abort_v[i] = 1'b0;
            iv_v[i] = 160'h0; block_v[i] = 512'h0;
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_abc();
        test_empty_all_r();
        test_back_to_back();
        test_resume();
        test_abort();
        test_cmd_handling();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sha1_core_mr.md
# sha1_core_mr

Parametrised SHA-1 compression core, successor to the single-round core: performs 1, 2 or 4 rounds per clock, can resume from an externally loaded chaining value, and can abort a block mid-computation. Sits between the UART byte/block assembler (which pads and frames 512-bit blocks) and the digest readout logic. The core accepts one pre-padded 512-bit block per start command and exposes the 160-bit chaining value.

## Interface
- ROUNDS_PER_CYCLE, default 1: rounds computed per clock. Legal values are 1, 2 and 4. Any other value is an elaboration error.
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- init  in  1  start the first block of a message: load the standard IV into H, then compress.
- next  in  1  start a continuation block from the current H.
- iv_load  in  1  load H from iv; no compression is performed.
- iv  in  160  chaining value for iv_load, ordered {H0,H1,H2,H3,H4}.
- abort  in  1  cancel the block in progress.
- block  in  512  message block, word 0 in bits [511:480]. Sampled only on the start edge.
- ready  out  1  core is idle and accepts commands.
- digest  out  160  {H0..H4} register contents.
- digest_valid  out  1  digest holds the result of a completed block.

## Operation
- FSM states: IDLE, ROUNDS, DONE.
- **IDLE**
  - ready=1.
  - Commands are sampled only in IDLE and ignored elsewhere, except abort.
  - Command priority is init > next > iv_load.
  - init:
    - H <= 67452301 efcdab89 98badcfe 10325476 c3d2e1f0.
    - a..e <= the same constants.
    - W window loaded from block; round_ctr <= 0; digest_valid <= 0.
    - Next state ROUNDS.
  - next: a..e <= H; W loaded from block; round_ctr <= 0; digest_valid <= 0; next state ROUNDS.
  - iv_load: H <= iv; digest_valid <= 0; stay in IDLE.
- **ROUNDS**
  - ready=0.
  - Each cycle applies R=ROUNDS_PER_CYCLE chained rounds t=round_ctr+i, i=0..R-1; round_ctr += R.
  - Because R divides 20, all R rounds in a cycle use one f/k group:
    - t 0–19: Ch, k=5a827999.
    - t 20–39: Parity, k=6ed9eba1.
    - t 40–59: Maj, k=8f1bbcdc.
    - t 60–79: Parity, k=ca62c1d6.
  - Round update: T = rotl5(a)+f(b,c,d)+e+k+W[t], mod 2^32. Then e<=d, d<=c, c<=rotl30(b), b<=a, a<=T.
  - When round_ctr == 80-R, next state is DONE.
- **DONE**
  - H_i <= H_i + {a..e}_i, mod 2^32.
  - digest_valid <= 1; next state IDLE.
- **abort**
  - Asserted in ROUNDS: next state IDLE; round_ctr <= 0.
  - H is unchanged. Because H was already rewritten at an init start, an aborted init leaves the standard IV in H. An aborted next leaves the previous H.
  - digest_valid stays 0.
  - abort in IDLE or DONE has no effect; DONE always completes.
- round_ctr is 7 bits and never exceeds 80-R.
- block may change freely after the start edge.

## Timing
- Reset values: ready=1, digest=0, digest_valid=0; FSM=IDLE; a..e, round_ctr and W all 0.
- Start sampled at edge S:
  - ROUNDS occupies edges S+1 .. S+80/R.
  - DONE occupies edge S+80/R+1.
  - digest_valid=1 and ready=1 are visible after that edge.
- Start-to-valid latency is 80/R+2 edges: 82 for R=1, 42 for R=2, 22 for R=4.
- Back-to-back: a next asserted in the first IDLE cycle after DONE is accepted, so throughput is 80/R+2 cycles per block.
- Abort sampled at edge A in ROUNDS: ready=1 after edge A, and the core accepts a new command at edge A+1.
- Reset asserted mid-operation returns immediately to the reset values above. There is no partial completion.
- Critical path is R chained round adders plus W generation. R=4 is the area/speed trade-off point and is not timing-closed at full clock; the integrator selects R.

## Structure
- **sha1_pkg** holds:
  - the H0_0..H0_4 constants;
  - the K constants;
  - the ctrl state enum (IDLE/ROUNDS/DONE);
  - SHA1_NUM_ROUNDS=80;
  - a round function f(t_group,b,c,d) and the rotl helpers.
- Sub-module **sha1_w_mem_mr** (param ROUNDS_PER_CYCLE):
  - 16×32 sliding window; init loads block, next advances by R.
  - Outputs w[R-1:0] for rounds t..t+R-1.
  - For t ≥ 16, W[t] = rotl1(W[t-3]^W[t-8]^W[t-14]^W[t-16]), chained within the cycle.
- Round datapath: a generate loop of R combinational round stages in the core.

## Test plan
- R=1: init with the padded "abc" block (61626380 00..00 00000018) -> after 82 edges digest_valid=1, digest=a9993e364706816aba3e25717850c26c9cd0d89d.
- R∈{1,2,4}: init on padded empty message (80000000, 0.., length 0) -> digest=da39a3ee5e6b4b0d3255bfef95601890afd80709; valid at 82/42/22 edges respectively.
- Two-block message "abcdbcdecdef…nopq":
  - Sequence: init block 1, wait valid, then next block 2.
  - Expected: digest=84983e441c3bd26ebaae4aa1f95129e5e54670f1, with next accepted in the first IDLE cycle.
- Resume path:
  - iv_load with the block-1 intermediate digest from the previous test, then next block 2.
  - Expected: digest=84983e441c3bd26ebaae4aa1f95129e5e54670f1, and digest_valid low between iv_load and completion.
- Abort path:
  - Abort on round cycle 10 of a next -> ready=1 next cycle, digest unchanged, digest_valid=0.
  - Then init "abc" -> correct abc digest.
- Command handling:
  - init+next+iv_load asserted together -> init behaviour.
  - Commands during ROUNDS are ignored.
  - reset_n pulsed mid-ROUNDS -> digest=0, digest_valid=0, ready=1.
